// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared constants and state encoding for the UART TX scheduler
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  localparam int UART_FRAME_MIN   = 11;
  localparam int DEF_FRAME_CYCLES = 12;
  localparam int DEF_INIT_CYCLES  = 2;
  localparam int BYTE_W           = 8;

  // Index width for NREQ requesters, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_scheduler_if.sv
// ============================================================================
// uart_tx_scheduler_if : requester / TX-unit signal bundle of the scheduler
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

interface uart_tx_scheduler_if
  import uart_pkg::*;
#(
  parameter int NREQ = 4
) ();

  localparam int ID_W = id_width(NREQ);

  logic [NREQ-1:0]        req;
  logic [NREQ*BYTE_W-1:0] data_in;
  logic [NREQ-1:0]        grant;
  logic                   tx_start;
  logic [BYTE_W-1:0]      tx_data;
  logic                   busy;
  logic [ID_W-1:0]        cur_id;

  modport master (
    output req, data_in,
    input  grant, tx_start, tx_data, busy, cur_id
  );

  modport slave (
    input  req, data_in,
    output grant, tx_start, tx_data, busy, cur_id
  );

endinterface

`default_nettype wire

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick, first request at/after pointer
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int ID_W = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] pointer,
  output logic [NREQ-1:0] grant_next,
  output logic [ID_W-1:0] winner,
  output logic            any_req
);

  logic found;
  int   idx;

  always_comb begin
    grant_next = '0;
    winner     = '0;
    any_req    = |req;
    found      = 1'b0;
    idx        = 0;
    for (int i = 0; i < NREQ; i++) begin
      // Walk from the pointer and wrap, so no requester has fixed priority.
      idx = int'(pointer) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found           = 1'b1;
        winner          = ID_W'(idx);
        grant_next[idx] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
// uart_tx_scheduler : shares one UART TX unit among NREQ byte requesters
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int INIT_CYCLES  = DEF_INIT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_scheduler_if.slave bus
);

  localparam int ID_W    = id_width(NREQ);
  localparam int CNT_MAX = (FRAME_CYCLES > INIT_CYCLES) ? FRAME_CYCLES : INIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t            state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [NREQ-1:0]   grant_q,    grant_d;
  logic              tx_start_q, tx_start_d;
  logic [BYTE_W-1:0] tx_data_q,  tx_data_d;
  logic [ID_W-1:0]   cur_id_q,   cur_id_d;
  logic [ID_W-1:0]   ptr_q,      ptr_d;
  logic              busy_q,     busy_d;

  logic [NREQ-1:0]   arb_grant;
  logic [ID_W-1:0]   arb_winner;
  logic              arb_any;

  rr_arbiter #(
    .NREQ       (NREQ)
  ) u_arb (
    .req        (bus.req),
    .pointer    (ptr_q),
    .grant_next (arb_grant),
    .winner     (arb_winner),
    .any_req    (arb_any)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_d    = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    cur_id_d   = cur_id_q;
    ptr_d      = ptr_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_IDLE: begin
        if (arb_any) begin
          state_d    = ST_START;
          grant_d    = arb_grant;
          tx_start_d = 1'b1;
          tx_data_d  = bus.data_in[int'(arb_winner)*BYTE_W +: BYTE_W];
          cur_id_d   = arb_winner;
          ptr_d      = (int'(arb_winner) == NREQ - 1) ? '0 : arb_winner + 1'b1;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
        cnt_d   = CNT_W'(FRAME_CYCLES - 1);
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_INIT;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_INIT;
      cnt_q      <= CNT_W'(INIT_CYCLES - 1);
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      cur_id_q   <= '0;
      ptr_q      <= '0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      cur_id_q   <= cur_id_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.cur_id   = cur_id_q;
  assign bus.busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// ============================================================================
// tb_uart_tx_scheduler : directed bench for the UART TX scheduler
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_scheduler;

  localparam int NREQ  = 4;
  localparam int FRAME = 12;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  uart_tx_scheduler_if #(.NREQ(NREQ)) bus ();

  uart_tx_scheduler #(
    .NREQ         (NREQ),
    .FRAME_CYCLES (FRAME),
    .INIT_CYCLES  (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  grant;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic [1:0]  cur_id;
  } vec_t;

  vec_t vt[$];
  int   n_pass  = 0;
  int   n_total = 0;

  int ev_id   [8];
  int ev_data [8];
  int ev_cyc  [8];
  int n_ev;

  localparam logic [31:0] BYTES = 32'h3130_2010;

  function automatic vec_t mk(input logic [3:0] r, input logic [31:0] d, input logic [3:0] g,
                              input logic ts, input logic [7:0] td, input logic b, input logic [1:0] id);
    vec_t v;
    v.req = r; v.data = d; v.grant = g; v.tx_start = ts; v.tx_data = td; v.busy = b; v.cur_id = id;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
  endtask

  // Runs up to ncyc cycles, logging each tx_start pulse and checking the
  // grant/tx_start pairing every cycle.
  task automatic capture(input int ncyc, input int maxev);
    n_ev = 0;
    for (int c = 1; c <= ncyc && n_ev < maxev; c++) begin
      tick();
      chk("grant_onehot0", 32'($countones(bus.grant) <= 1), 32'd1);
      chk("grant_with_start", 32'(bus.grant != 4'b0), 32'(bus.tx_start));
      if (bus.tx_start) begin
        ev_id[n_ev]   = (bus.grant[0]) ? 0 : (bus.grant[1]) ? 1 : (bus.grant[2]) ? 2 : 3;
        ev_data[n_ev] = int'(bus.tx_data);
        ev_cyc[n_ev]  = c;
        n_ev++;
      end
    end
    chk("capture_events", 32'(n_ev), 32'(maxev));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int exp_id3   [5];
    int exp_data3 [5];
    int wcyc;
    bit seen_idle;

    exp_id3   = '{0, 1, 2, 3, 0};
    exp_data3 = '{32'h10, 32'h20, 32'h30, 32'h31, 32'h10};

    bus.req     = '0;
    bus.data_in = '0;

    // Reset / INIT timing and a single request, cycle by cycle.
    vt.push_back(mk(4'b0000, 32'h41, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd0));
    vt.push_back(mk(4'b0000, 32'h41, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0));
    vt.push_back(mk(4'b0000, 32'h41, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0));
    vt.push_back(mk(4'b0001, 32'h41, 4'b0001, 1'b1, 8'h41, 1'b1, 2'd0));
    for (int i = 0; i < FRAME; i++)
      vt.push_back(mk(4'b0000, 32'h41, 4'b0000, 1'b0, 8'h41, 1'b1, 2'd0));
    vt.push_back(mk(4'b0000, 32'h41, 4'b0000, 1'b0, 8'h41, 1'b0, 2'd0));

    do_reset();
    chk("rst_grant",    32'(bus.grant),    32'h0);
    chk("rst_tx_start", 32'(bus.tx_start), 32'h0);
    chk("rst_tx_data",  32'(bus.tx_data),  32'h0);
    chk("rst_cur_id",   32'(bus.cur_id),   32'h0);
    chk("rst_busy",     32'(bus.busy),     32'h1);

    for (int i = 0; i < vt.size(); i++) begin
      bus.req     = vt[i].req;
      bus.data_in = vt[i].data;
      tick();
      chk($sformatf("v%0d_grant", i),    32'(bus.grant),    32'(vt[i].grant));
      chk($sformatf("v%0d_tx_start", i), 32'(bus.tx_start), 32'(vt[i].tx_start));
      chk($sformatf("v%0d_tx_data", i),  32'(bus.tx_data),  32'(vt[i].tx_data));
      chk($sformatf("v%0d_busy", i),     32'(bus.busy),     32'(vt[i].busy));
      chk($sformatf("v%0d_cur_id", i),   32'(bus.cur_id),   32'(vt[i].cur_id));
    end

    // All four requesting: round-robin order and frame spacing.
    bus.data_in = BYTES;
    bus.req     = 4'b1111;
    do_reset();
    capture(100, 5);
    chk("rr_first_cycle", 32'(ev_cyc[0]), 32'd3);
    for (int k = 0; k < n_ev; k++) begin
      chk($sformatf("rr_id%0d", k),   32'(ev_id[k]),   32'(exp_id3[k]));
      chk($sformatf("rr_data%0d", k), 32'(ev_data[k]), 32'(exp_data3[k]));
      if (k > 0) chk($sformatf("rr_gap%0d", k), 32'(ev_cyc[k] - ev_cyc[k-1]), 32'(FRAME + 2));
    end

    // Requesters 0 and 2 only: must alternate.
    bus.req = 4'b0101;
    do_reset();
    capture(100, 4);
    for (int k = 0; k < n_ev; k++)
      chk($sformatf("fair_id%0d", k), 32'(ev_id[k]), 32'((k % 2 == 0) ? 0 : 2));

    // Late arrival of requester 3 during requester 1's frame.
    bus.req = 4'b0000;
    do_reset();
    tick();
    tick();
    chk("late_idle_busy", 32'(bus.busy), 32'h0);
    bus.req = 4'b0010;
    tick();
    chk("late_grant1", 32'(bus.grant), 32'h2);
    bus.req   = 4'b0000;
    wcyc      = 0;
    seen_idle = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      chk("late_no_early_grant", 32'(bus.grant), 32'h0);
      if (!bus.busy) begin
        seen_idle = 1'b1;
        break;
      end
      wcyc++;
      if (wcyc == 6) bus.req = 4'b1000;
    end
    chk("late_idle_reached", 32'(seen_idle), 32'h1);
    chk("late_wait_len", 32'(wcyc), 32'(FRAME));
    tick();
    chk("late_grant3",    32'(bus.grant),    32'h8);
    chk("late_tx_start",  32'(bus.tx_start), 32'h1);
    chk("late_cur_id",    32'(bus.cur_id),   32'h3);
    chk("late_tx_data",   32'(bus.tx_data),  32'h31);

    // Reset in the middle of WAIT with the counter at 5.
    bus.req = 4'b0000;
    tick();
    repeat (6) tick();
    bus.req = 4'b1111;
    reset   = 1'b0;
    tick();
    chk("mid_rst_grant",    32'(bus.grant),    32'h0);
    chk("mid_rst_tx_start", 32'(bus.tx_start), 32'h0);
    chk("mid_rst_tx_data",  32'(bus.tx_data),  32'h0);
    chk("mid_rst_cur_id",   32'(bus.cur_id),   32'h0);
    chk("mid_rst_busy",     32'(bus.busy),     32'h1);
    reset = 1'b1;
    tick();
    chk("post_rst_tx_start", 32'(bus.tx_start), 32'h0);
    chk("post_rst_busy",     32'(bus.busy),     32'h1);
    tick();
    chk("post_rst_idle_start", 32'(bus.tx_start), 32'h0);
    chk("post_rst_idle_busy",  32'(bus.busy),     32'h0);
    tick();
    chk("post_rst_grant",   32'(bus.grant),   32'h1);
    chk("post_rst_cur_id",  32'(bus.cur_id),  32'h0);
    chk("post_rst_tx_data", 32'(bus.tx_data), 32'h10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
